// File: rtl/ext_bus_ctrl_pkg.sv
// Shared types and default timing for the external bus controller.
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam int unsigned DEF_SETUP_CYC   = 1;
  localparam int unsigned DEF_WAIT_CYC    = 2;
  localparam int unsigned DEF_TIMEOUT_CYC = 64;

  localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

endpackage

// File: rtl/ext_bus_ctrl_if.sv
// CPU-side request/response handshake of the external bus controller.
interface ext_bus_ctrl_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    output req, we, addr, wdata,
    input  rdata, busy, done, timeout
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, busy, done, timeout
  );

endinterface

// File: rtl/ext_bus_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resb,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!resb) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ext_bus_ctrl.sv
// Sequences off-chip CPU accesses through setup, strobe (wait-state / ready stretched) and hold phases.
module ext_bus_ctrl
  import ext_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned WAIT_CYC    = DEF_WAIT_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        resb,
  ext_bus_ctrl_if.slave bus,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_doe,
  output logic        ext_rwb,
  output logic        ext_csb,
  output logic        ext_strb,
  input  logic        ext_rdy,
  input  logic [7:0]  ext_din
);

  // One counter serves both the setup and strobe phases, so size it for the longer.
  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_N = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] WAIT_N  = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] TOUT_N  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rdy_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rdy_sync (
    .clk  (clk),
    .resb (resb),
    .d    (ext_rdy),
    .q    (rdy_s)
  );

  always_ff @(posedge clk) begin
    if (!resb) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.rdata   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      ext_addr    <= '0;
      ext_dout    <= '0;
      ext_doe     <= 1'b0;
      ext_rwb     <= 1'b1;
      ext_csb     <= 1'b1;
      ext_strb    <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            ext_addr <= bus.addr;
            ext_rwb  <= ~bus.we;
            ext_dout <= bus.wdata;
            ext_doe  <= bus.we;
            ext_csb  <= 1'b0;
            bus.busy <= 1'b1;
            cnt      <= ONE;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt >= SETUP_N) begin
            ext_strb <= 1'b1;
            cnt      <= ONE;
            state    <= STROBE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        STROBE: begin
          // A ready device wins over the terminal count when both land on the same edge.
          if (cnt >= WAIT_N && rdy_s) begin
            ext_strb <= 1'b0;
            bus.done <= 1'b1;
            if (ext_rwb) bus.rdata <= ext_din;
            state    <= HOLD;
          end else if (cnt == TOUT_N) begin
            ext_strb    <= 1'b0;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
            if (ext_rwb) bus.rdata <= RDATA_TIMEOUT;
            state       <= HOLD;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HOLD: begin
          ext_csb  <= 1'b1;
          ext_doe  <= 1'b0;
          ext_rwb  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Randomized self-checking bench for ext_bus_ctrl against a cycle-level access model.
module tb_ext_bus_ctrl;

  localparam int SETUP   = 1;
  localparam int WAITC   = 2;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        resb;
  logic [15:0] ext_addr;
  logic [7:0]  ext_dout;
  logic        ext_doe;
  logic        ext_rwb;
  logic        ext_csb;
  logic        ext_strb;
  logic        ext_rdy;
  logic [7:0]  ext_din;

  ext_bus_ctrl_if bus ();

  ext_bus_ctrl #(
    .SETUP_CYC   (SETUP),
    .WAIT_CYC    (WAITC),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk      (clk),
    .resb     (resb),
    .bus      (bus),
    .ext_addr (ext_addr),
    .ext_dout (ext_dout),
    .ext_doe  (ext_doe),
    .ext_rwb  (ext_rwb),
    .ext_csb  (ext_csb),
    .ext_strb (ext_strb),
    .ext_rdy  (ext_rdy),
    .ext_din  (ext_din)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_rdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ext_rdy as sampled at edge j (relative to the accepting edge); low only inside the window.
  function automatic logic rdy_at(input int j, input int lo_s, input int lo_l);
    return !(lo_l > 0 && j >= lo_s && j < lo_s + lo_l);
  endfunction

  // Strobe length k and whether the access times out: the controller sees ext_rdy two edges late,
  // may finish once k reaches the wait minimum with ready seen, and must finish at the timeout.
  task automatic model(input int lo_s, input int lo_l, output int k, output bit to);
    to = 1'b0;
    for (k = 1; k <= TIMEOUT; k++) begin
      if (k >= WAITC && rdy_at(SETUP + k - 2, lo_s, lo_l)) return;
      if (k == TIMEOUT) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] din, input int lo_s, input int lo_l, input bit spur,
                        output int done_at, output int strb_n);
    int k;
    bit to;
    int x;
    model(lo_s, lo_l, k, to);
    x = SETUP + k;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    ext_din   = din;
    ext_rdy   = rdy_at(0, lo_s, lo_l);
    done_at   = -1;
    strb_n    = 0;
    for (int j = 0; j <= x + 1; j++) begin
      @(posedge clk);
      #1;
      if (spur && j < x) begin
        bus.req   = 1'b1;
        bus.addr  = 16'($urandom);
        bus.we    = 1'($urandom);
        bus.wdata = 8'($urandom);
      end else begin
        bus.req = 1'b0;
      end
      ext_rdy = (j + 1 > x) ? 1'b1 : rdy_at(j + 1, lo_s, lo_l);
      if (bus.done && done_at < 0) done_at = j;
      if (ext_strb) strb_n++;
      if (j <= x) begin
        if (j == x && !w) exp_rdata = to ? 8'hFF : din;
        chk("busy",    32'(bus.busy),    32'(1));
        chk("csb",     32'(ext_csb),     32'(0));
        chk("strb",    32'(ext_strb),    32'(j >= SETUP && j < x));
        chk("done",    32'(bus.done),    32'(j == x));
        chk("timeout", 32'(bus.timeout), 32'(j == x && to));
        chk("addr",    32'(ext_addr),    32'(a));
        chk("rwb",     32'(ext_rwb),     32'(!w));
        chk("doe",     32'(ext_doe),     32'(w));
        if (w) chk("dout", 32'(ext_dout), 32'(d));
        if (j == x) chk("rdata_hold", 32'(bus.rdata), 32'(exp_rdata));
      end else begin
        chk("idle_busy",  32'(bus.busy),  32'(0));
        chk("idle_csb",   32'(ext_csb),   32'(1));
        chk("idle_doe",   32'(ext_doe),   32'(0));
        chk("idle_rwb",   32'(ext_rwb),   32'(1));
        chk("idle_done",  32'(bus.done),  32'(0));
        chk("idle_strb",  32'(ext_strb),  32'(0));
        chk("idle_rdata", 32'(bus.rdata), 32'(exp_rdata));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rdata"},   32'(bus.rdata),   32'(8'h00));
    chk({tag, "_busy"},    32'(bus.busy),    32'(0));
    chk({tag, "_done"},    32'(bus.done),    32'(0));
    chk({tag, "_timeout"}, 32'(bus.timeout), 32'(0));
    chk({tag, "_addr"},    32'(ext_addr),    32'(16'h0000));
    chk({tag, "_dout"},    32'(ext_dout),    32'(8'h00));
    chk({tag, "_doe"},     32'(ext_doe),     32'(0));
    chk({tag, "_rwb"},     32'(ext_rwb),     32'(1));
    chk({tag, "_csb"},     32'(ext_csb),     32'(1));
    chk({tag, "_strb"},    32'(ext_strb),    32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int da;
    int sn;
    resb      = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    ext_rdy   = 1'b1;
    ext_din   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    resb = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Default read
    access(1'b0, 16'h9000, 8'h00, 8'hA5, 0, 0, 1'b0, da, sn);
    chk("t1_latency", 32'(da + 1), 32'(4));
    chk("t1_strobe",  32'(sn),     32'(2));
    chk("t1_rdata",   32'(bus.rdata), 32'(8'hA5));

    // Write; rdata must keep the previous read value
    access(1'b1, 16'hA001, 8'h3C, 8'h5A, 0, 0, 1'b0, da, sn);
    chk("t2_rdata_kept", 32'(bus.rdata), 32'(8'hA5));

    // ext_rdy low for 5 sampled edges starting at the strobe rise
    access(1'b0, 16'h9123, 8'h00, 8'h77, 1, 5, 1'b0, da, sn);
    chk("t3_strobe",  32'(sn),     32'(7));
    chk("t3_latency", 32'(da + 1), 32'(SETUP + 7 + 1));

    // ext_rdy never returns
    access(1'b0, 16'h8000, 8'h00, 8'h12, 0, 200, 1'b0, da, sn);
    chk("t4_strobe", 32'(sn),        32'(TIMEOUT));
    chk("t4_rdata",  32'(bus.rdata), 32'(8'hFF));

    // Back-to-back reads with spurious requests while busy
    access(1'b0, 16'hC000, 8'h00, 8'h11, 0, 0, 1'b1, da, sn);
    access(1'b0, 16'hC001, 8'h00, 8'h22, 0, 0, 1'b1, da, sn);
    chk("t6_rdata", 32'(bus.rdata), 32'(8'h22));

    // Reset during strobe
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 16'hB00B;
    ext_din  = 8'h99;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk("t5_strobe_on", 32'(ext_strb), 32'(1));
    resb = 1'b0;
    @(posedge clk); #1;
    exp_rdata = 8'h00;
    check_reset_state("t5");
    resb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_done", 32'(bus.done), 32'(0));
      chk("t5_no_busy", 32'(bus.busy), 32'(0));
    end
    access(1'b0, 16'hB00C, 8'h00, 8'h66, 0, 0, 1'b0, da, sn);
    chk("t5_after", 32'(da + 1), 32'(4));

    // Randomized accesses
    for (int i = 0; i < 24; i++) begin
      int lo_s;
      int lo_l;
      lo_s = int'($urandom_range(0, 4));
      lo_l = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 8));
      access(1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             lo_s, lo_l, 1'($urandom), da, sn);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
